matmul_sequencer: RTL
=====================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: element width in bits.
REQ-002 Parameter BUS_WIDTH, default 64: bus width in bits; MAX_DIM = BUS_WIDTH/DATA_WIDTH, ROW_W = max(1, clog2(MAX_DIM)), CNT_W = clog2(3*MAX_DIM).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 start_bit_i  in  1  start bit from the control register, level.
REQ-007 n_dim_i, k_dim_i, m_dim_i  in  2 each  dimension fields; size = field+1.
REQ-008 mode_bit_i  in  1  0 = overwrite scratchpad, 1 = accumulate into scratchpad.
REQ-009 start_send_o  out  1  one-cycle pulse telling operand A/B buffers to begin shifting.
REQ-010 pe_enable_o  out  1  processing-element array enable.
REQ-011 sp_we_o  out  1  scratchpad row write enable.
REQ-012 sp_acc_o  out  1  accumulate qualifier for sp_we_o.
REQ-013 sp_row_o  out  ROW_W  scratchpad row index.
REQ-014 busy_o  out  1  sequence in progress.
REQ-015 clear_start_o  out  1  one-cycle pulse clearing the control start bit.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, COMPUTE, WRITEBACK, DONE, all outputs Moore-decoded from registered state and counter.
REQ-017 Effective sizes N, K, M SHALL be min(field+1, MAX_DIM), latched on the IDLE->LOAD transition and held until IDLE.
REQ-018 IDLE->LOAD on a clock edge with start_bit_i=1; otherwise IDLE is held.
REQ-019 LOAD SHALL last exactly 1 cycle with start_send_o=1, then go to COMPUTE with counter cleared.
REQ-020 COMPUTE SHALL last C = N+K+M-2 cycles with pe_enable_o=1; counter width CNT_W, no wrap.
REQ-021 WRITEBACK SHALL last N cycles with sp_we_o=1, sp_row_o = 0..N-1 ascending, sp_acc_o = latched mode_bit_i.
REQ-022 DONE SHALL last 1 cycle with clear_start_o=1, then go to IDLE.
REQ-023 busy_o SHALL be 1 in LOAD, COMPUTE, WRITEBACK and DONE.
REQ-024 Total latency from the sampling edge to return to IDLE SHALL be C+N+2 cycles.
REQ-025 start_bit_i, dimension and mode changes while busy_o=1 SHALL be ignored.
REQ-026 start_bit_i still 1 in the first IDLE cycle after DONE SHALL start a new sequence (back-to-back).
REQ-027 sp_row_o, sp_acc_o SHALL be 0 outside WRITEBACK.

Reset
REQ-028 rst_ni low SHALL force IDLE, clear counter, latched sizes and mode, and drive every output to 0 immediately, including mid-sequence.
REQ-029 After rst_ni release, the first start SHALL be sampled on the first rising edge with rst_ni high.

Configuration
REQ-030 With MATMUL_SEQ_CYCLE_COUNT_EN defined, port cycle_cnt_o (out, 16) SHALL count cycles with busy_o=1, clear on IDLE->LOAD, saturate at 0xFFFF, reset to 0.
REQ-031 Without MATMUL_SEQ_CYCLE_COUNT_EN, cycle_cnt_o and its register SHALL not exist; all other behaviour is identical.

Structure
REQ-032 Shared package matmul_pkg SHALL hold the FSM state enum, MAX_DIM/ROW_W/CNT_W derivations and the dimension-field width.
REQ-033 One sub-module seq_counter (load-clear, enable, terminal-count flag) SHALL serve both COMPUTE and WRITEBACK counting.

Verification
REQ-034 Reset then start=1, n=k=m=1 (MAX_DIM=2) -> LOAD 1 cycle, pe_enable_o 4 cycles, sp_we_o rows 0,1, clear_start_o at cycle 8, IDLE at 8.
REQ-035 n=0,k=1,m=0, mode=1 -> C=2, single WRITEBACK cycle row 0 with sp_acc_o=1, total latency 5.
REQ-036 Fields=3 with MAX_DIM=2 -> clamped to 2, same timing as REQ-034.
REQ-037 Toggle start_bit_i and change dims during COMPUTE -> no restart, timing unchanged; start held high through DONE -> second sequence begins immediately.
REQ-038 Assert rst_ni low in WRITEBACK row 0 -> all outputs 0 same cycle, IDLE after release, no clear_start_o.
REQ-039 With MATMUL_SEQ_CYCLE_COUNT_EN, REQ-034 run -> cycle_cnt_o = 8 in IDLE; next start -> 0 then counts again.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and size derivations for the matrix-multiply sequencer.
// Widths follow from BUS_WIDTH/DATA_WIDTH through the helper functions below.
package matmul_pkg;

    localparam int DIM_FIELD_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_WRITEBACK,
        ST_DONE
    } seq_state_e;

    function automatic int calc_max_dim(input int bus_w, input int data_w);
        return bus_w / data_w;
    endfunction

    // A single-row array still needs a one-bit row index port.
    function automatic int calc_row_w(input int max_dim);
        return (max_dim <= 1) ? 1 : $clog2(max_dim);
    endfunction

    function automatic int calc_cnt_w(input int max_dim);
        return $clog2(3 * max_dim);
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Control-register and datapath-control bundle of the matmul sequencer.
// Signal suffixes are from the sequencer's point of view.
interface matmul_sequencer_if #(
    parameter int ROW_W = 1
);

    logic                                start_bit_i;
    logic [matmul_pkg::DIM_FIELD_W-1:0]  n_dim_i;
    logic [matmul_pkg::DIM_FIELD_W-1:0]  k_dim_i;
    logic [matmul_pkg::DIM_FIELD_W-1:0]  m_dim_i;
    logic                                mode_bit_i;

    logic                                start_send_o;
    logic                                pe_enable_o;
    logic                                sp_we_o;
    logic                                sp_acc_o;
    logic [ROW_W-1:0]                    sp_row_o;
    logic                                busy_o;
    logic                                clear_start_o;

    modport slave (
        input  start_bit_i, n_dim_i, k_dim_i, m_dim_i, mode_bit_i,
        output start_send_o, pe_enable_o, sp_we_o, sp_acc_o, sp_row_o,
               busy_o, clear_start_o
    );

    modport master (
        output start_bit_i, n_dim_i, k_dim_i, m_dim_i, mode_bit_i,
        input  start_send_o, pe_enable_o, sp_we_o, sp_acc_o, sp_row_o,
               busy_o, clear_start_o
    );

endinterface

// File: rtl/matmul_sequencer_counter.sv
// Phase counter shared by COMPUTE and WRITEBACK: clear, count-enable,
// saturating at all-ones, terminal flag when the count equals last_i.
module seq_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] last_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == last_i);

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for the systolic matmul: LOAD -> COMPUTE -> WRITEBACK -> DONE.
// Optional busy-cycle counter port enabled by defining MATMUL_SEQ_CYCLE_COUNT_EN.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    matmul_sequencer_if.slave    bus
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]          cycle_cnt_o
`endif
);

    localparam int MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
    localparam int ROW_W   = calc_row_w(MAX_DIM);
    localparam int CNT_W   = calc_cnt_w(MAX_DIM);

    typedef logic [CNT_W-1:0] cnt_t;

    seq_state_e state_q, state_d;
    cnt_t       n_q, n_d;
    cnt_t       k_q, k_d;
    cnt_t       m_q, m_d;
    logic       mode_q, mode_d;

    cnt_t       cnt;
    cnt_t       cnt_last;
    cnt_t       compute_last;
    cnt_t       wb_last;
    logic       cnt_tc;
    logic       cnt_clear;
    logic       cnt_en;

    logic             start_send;
    logic             pe_enable;
    logic             sp_we;
    logic             sp_acc;
    logic [ROW_W-1:0] sp_row;
    logic             busy;
    logic             clear_start;

    function automatic cnt_t clamp_dim(input logic [DIM_FIELD_W-1:0] field);
        int size;
        size = int'(field) + 1;
        if (size > MAX_DIM) begin
            size = MAX_DIM;
        end
        return cnt_t'(size);
    endfunction

    // COMPUTE runs N+K+M-2 cycles, so its terminal count is N+K+M-3.
    assign compute_last = n_q + k_q + m_q - cnt_t'(3);
    assign wb_last      = n_q - cnt_t'(1);

    seq_counter #(
        .WIDTH (CNT_W)
    ) u_phase_cnt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (cnt_clear),
        .enable_i (cnt_en),
        .last_i   (cnt_last),
        .count_o  (cnt),
        .tc_o     (cnt_tc)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        m_d       = m_q;
        mode_d    = mode_q;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        cnt_last  = compute_last;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_bit_i) begin
                    state_d = ST_LOAD;
                    n_d     = clamp_dim(bus.n_dim_i);
                    k_d     = clamp_dim(bus.k_dim_i);
                    m_d     = clamp_dim(bus.m_dim_i);
                    mode_d  = bus.mode_bit_i;
                end
            end
            ST_LOAD: begin
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                cnt_clear = cnt_tc;
                cnt_en    = 1'b1;
                cnt_last  = compute_last;
                if (cnt_tc) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                cnt_clear = cnt_tc;
                cnt_en    = 1'b1;
                cnt_last  = wb_last;
                if (cnt_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            m_q     <= m_d;
            mode_q  <= mode_d;
        end
    end

    // Outputs depend only on registered state and count, so reset clears them at once.
    always_comb begin
        start_send  = 1'b0;
        pe_enable   = 1'b0;
        sp_we       = 1'b0;
        sp_acc      = 1'b0;
        sp_row      = '0;
        busy        = 1'b1;
        clear_start = 1'b0;

        case (state_q)
            ST_IDLE:      busy = 1'b0;
            ST_LOAD:      start_send = 1'b1;
            ST_COMPUTE:   pe_enable = 1'b1;
            ST_WRITEBACK: begin
                sp_we  = 1'b1;
                sp_acc = mode_q;
                sp_row = cnt[ROW_W-1:0];
            end
            ST_DONE:      clear_start = 1'b1;
            default:      busy = 1'b0;
        endcase
    end

    assign bus.start_send_o  = start_send;
    assign bus.pe_enable_o   = pe_enable;
    assign bus.sp_we_o       = sp_we;
    assign bus.sp_acc_o      = sp_acc;
    assign bus.sp_row_o      = sp_row;
    assign bus.busy_o        = busy;
    assign bus.clear_start_o = clear_start;

`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (state_q == ST_IDLE) begin
            if (bus.start_bit_i) begin
                cycle_cnt_d = '0;
            end
        end else if (cycle_cnt_q != 16'hFFFF) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule
